eth_rx_frame_buffer: RTL and testbench

//  Store-and-forward RX frame buffer between the Ethernet MAC stream and ethernet_service in_* port.

---
 rtl/eth_pkg.sv | 23 ++
 rtl/eth_rx_buf_ram.sv | 37 +++
 rtl/eth_rx_frame_buffer.sv | 189 ++++++++++++++++++
 tb/tb_eth_rx_frame_buffer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types for the Ethernet RX frame buffer.
// Contents: beat payload struct stored per RAM entry, write-side FSM state encoding,
// and the data/empty field widths of the 512b MAC stream.
package eth_pkg;

   localparam int unsigned ETH_DATA_W  = 512;
   localparam int unsigned ETH_EMPTY_W = 6;

   // One stream beat as stored in the buffer RAM
   typedef struct packed {
      logic [ETH_DATA_W-1:0]  data;
      logic                   sop;
      logic                   eop;
      logic [ETH_EMPTY_W-1:0] empty;
   } eth_beat_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DROP = 2'd2
   } rxbuf_state_e;

endpackage

// File: rtl/eth_rx_buf_ram.sv
// Simple dual-port beat RAM, one write port and one registered read port.
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable; rdata_o updates only when asserted
//   raddr_i  in   read address
//   rdata_o  out  read data, one cycle after re_i (held otherwise)
module eth_rx_buf_ram
   import eth_pkg::*;
#(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned WIDTH  = $bits(eth_beat_t)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Storage array and read register; rdata holds its value while re_i is low
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// Store-and-forward RX frame buffer between the MAC beat stream and the service input.
// Whole packets are written speculatively and only become readable once their eop beat
// lands; overflow, framing errors and oversized packets are rewound and counted.
// Optional feature macro: ETH_RX_FCS_DROP_EN adds mac_error; an errored eop drops the packet.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   mac_valid/data/sop/eop/empty   MAC beat input, no backpressure
//   mac_error             FCS/PHY error on eop (ETH_RX_FCS_DROP_EN only)
//   out_valid/ready/data/sop/eop/empty   downstream beat stream
//   pkt_count, drop_count saturating status counters
module eth_rx_frame_buffer
   import eth_pkg::*;
#(
   parameter int unsigned DEPTH         = 64,
   parameter int unsigned MAX_PKT_BEATS = 24,
   parameter int unsigned CNT_W         = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mac_valid,
   input  logic [ETH_DATA_W-1:0]  mac_data,
   input  logic                   mac_sop,
   input  logic                   mac_eop,
   input  logic [ETH_EMPTY_W-1:0] mac_empty,
`ifdef ETH_RX_FCS_DROP_EN
   input  logic                   mac_error,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ETH_DATA_W-1:0]  out_data,
   output logic                   out_sop,
   output logic                   out_eop,
   output logic [ETH_EMPTY_W-1:0] out_empty,
   output logic [CNT_W-1:0]       pkt_count,
   output logic [CNT_W-1:0]       drop_count
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam int unsigned BEAT_W = $clog2(MAX_PKT_BEATS + 2);

   rxbuf_state_e      state_q, state_d;
   logic [PTR_W-1:0]  wr_spec_q, wr_spec_d;
   logic [PTR_W-1:0]  wr_commit_q, wr_commit_d;
   logic [PTR_W-1:0]  rd_q;
   logic [BEAT_W-1:0] beats_q, beats_d;
   logic [CNT_W-1:0]  pkt_count_q, drop_count_q;
   eth_beat_t         out_q;
   logic              out_valid_q;
   logic              ram_vld_q;

   logic              we_c;
   logic [ADDR_W-1:0] waddr_c;
   logic [PTR_W-1:0]  base_c;
   logic              full_c;
   logic              pkt_inc_c, drop_inc_c;
   logic              fcs_err_c;
   logic              move_c, issue_c;
   eth_beat_t         wbeat_c, rbeat_c;

`ifdef ETH_RX_FCS_DROP_EN
   assign fcs_err_c = mac_error;
`else
   assign fcs_err_c = 1'b0;
`endif

   assign wbeat_c = '{data: mac_data, sop: mac_sop, eop: mac_eop, empty: mac_empty};

   // A new sop always restarts at the commit point, discarding any partial packet
   assign base_c = mac_sop ? wr_commit_q : wr_spec_q;
   assign full_c = (base_c - rd_q) == PTR_W'(DEPTH);

   // Write-side next state: accept, commit, rewind or discard the incoming beat
   always_comb begin
      state_d     = state_q;
      wr_spec_d   = wr_spec_q;
      wr_commit_d = wr_commit_q;
      beats_d     = beats_q;
      we_c        = 1'b0;
      waddr_c     = base_c[ADDR_W-1:0];
      pkt_inc_c   = 1'b0;
      drop_inc_c  = 1'b0;
      if (mac_valid) begin
         if (mac_sop || (state_q == RECV)) begin
            if (mac_sop && (state_q == RECV)) drop_inc_c = 1'b1;
            if (full_c || (!mac_sop && (beats_q == BEAT_W'(MAX_PKT_BEATS)))) begin
               drop_inc_c = 1'b1;
               wr_spec_d  = wr_commit_q;
               state_d    = mac_eop ? IDLE : DROP;
            end else begin
               we_c      = 1'b1;
               wr_spec_d = base_c + PTR_W'(1);
               beats_d   = mac_sop ? BEAT_W'(1) : beats_q + BEAT_W'(1);
               if (mac_eop) begin
                  state_d = IDLE;
                  if (fcs_err_c) begin
                     drop_inc_c = 1'b1;
                     wr_spec_d  = wr_commit_q;
                  end else begin
                     wr_commit_d = base_c + PTR_W'(1);
                     pkt_inc_c   = 1'b1;
                  end
               end else begin
                  state_d = RECV;
               end
            end
         end else if (state_q == IDLE) begin
            // Stray continuation beat with no packet open
            drop_inc_c = 1'b1;
            state_d    = mac_eop ? IDLE : DROP;
         end else if (mac_eop) begin
            state_d = IDLE;
         end
      end
   end

   // Read pipeline: RAM register feeds the output register; fetch only when a slot frees
   assign move_c  = ram_vld_q && (!out_valid_q || out_ready);
   assign issue_c = (rd_q != wr_commit_q) && (!ram_vld_q || move_c);

   eth_rx_buf_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  ($bits(eth_beat_t))
   ) u_ram (
      .clk     (clk),
      .we_i    (we_c),
      .waddr_i (waddr_c),
      .wdata_i (wbeat_c),
      .re_i    (issue_c),
      .raddr_i (rd_q[ADDR_W-1:0]),
      .rdata_o (rbeat_c)
   );

   // Write-side state and pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_spec_q   <= '0;
         wr_commit_q <= '0;
         beats_q     <= '0;
      end else begin
         state_q     <= state_d;
         wr_spec_q   <= wr_spec_d;
         wr_commit_q <= wr_commit_d;
         beats_q     <= beats_d;
      end
   end

   // Read pointer, RAM-valid flag and output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q        <= '0;
         ram_vld_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         if (issue_c) rd_q <= rd_q + PTR_W'(1);
         if (issue_c)     ram_vld_q <= 1'b1;
         else if (move_c) ram_vld_q <= 1'b0;
         if (move_c) begin
            out_q       <= rbeat_c;
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Saturating status counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count_q  <= '0;
         drop_count_q <= '0;
      end else begin
         if (pkt_inc_c && (pkt_count_q != '1))   pkt_count_q  <= pkt_count_q + CNT_W'(1);
         if (drop_inc_c && (drop_count_q != '1)) drop_count_q <= drop_count_q + CNT_W'(1);
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_q.data;
   assign out_sop    = out_q.sop;
   assign out_eop    = out_q.eop;
   assign out_empty  = out_q.empty;
   assign pkt_count  = pkt_count_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Scoreboard bench for eth_rx_frame_buffer: the driver pushes beats expected downstream,
// an independent monitor pops and compares on every out_valid & out_ready.
module tb_eth_rx_frame_buffer;
   import eth_pkg::*;

   localparam int unsigned CNT_W = 32;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   mac_valid, mac_sop, mac_eop;
   logic [ETH_DATA_W-1:0]  mac_data;
   logic [ETH_EMPTY_W-1:0] mac_empty;
`ifdef ETH_RX_FCS_DROP_EN
   logic                   mac_error;
`endif
   logic                   out_valid, out_ready, out_sop, out_eop;
   logic [ETH_DATA_W-1:0]  out_data;
   logic [ETH_EMPTY_W-1:0] out_empty;
   logic [CNT_W-1:0]       pkt_count, drop_count;

   eth_beat_t exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int exp_pkt  = 0;
   int exp_drop = 0;

   always #5 clk = ~clk;

   eth_rx_frame_buffer #(.DEPTH(64), .MAX_PKT_BEATS(24), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mac_valid  (mac_valid),
      .mac_data   (mac_data),
      .mac_sop    (mac_sop),
      .mac_eop    (mac_eop),
      .mac_empty  (mac_empty),
`ifdef ETH_RX_FCS_DROP_EN
      .mac_error  (mac_error),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sop    (out_sop),
      .out_eop    (out_eop),
      .out_empty  (out_empty),
      .pkt_count  (pkt_count),
      .drop_count (drop_count)
   );

   function automatic logic [ETH_DATA_W-1:0] mk(input int p, input int b);
      logic [31:0] w;
      w = {p[15:0], b[15:0]};
      return {16{w}};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input int p, input int b, input logic sop, input logic eop,
                       input logic [5:0] emp, input logic err, input logic keep);
      @(posedge clk); #1;
      mac_valid = 1'b1;
      mac_data  = mk(p, b);
      mac_sop   = sop;
      mac_eop   = eop;
      mac_empty = emp;
`ifdef ETH_RX_FCS_DROP_EN
      mac_error = err;
`else
      if (err) $display("note: error flag ignored in this build");
`endif
      if (keep) exp_q.push_back('{data: mk(p, b), sop: sop, eop: eop, empty: emp});
   endtask

   task automatic send_pkt(input int p, input int n, input logic [5:0] emp, input logic keep);
      for (int b = 0; b < n; b++)
         send(p, b, b == 0, b == n - 1, (b == n - 1) ? emp : 6'd0, 1'b0, keep);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      mac_valid = 1'b0;
      mac_sop   = 1'b0;
      mac_eop   = 1'b0;
`ifdef ETH_RX_FCS_DROP_EN
      mac_error = 1'b0;
`endif
   endtask

   task automatic set_ready(input logic r);
      @(posedge clk); #1;
      out_ready = r;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clk);
      chk({name, "_idle"}, {63'd0, out_valid}, 64'd0);
   endtask

   task automatic chk_counts(input string name);
      chk({name, "_pkt"}, 64'(pkt_count), 64'(exp_pkt));
      chk({name, "_drop"}, 64'(drop_count), 64'(exp_drop));
   endtask

   // Monitor: compare every handshaken beat and check hold during stalls
   initial begin
      eth_beat_t cur, prev, e;
      logic      prev_stall;
      prev_stall = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         cur = '{data: out_data, sop: out_sop, eop: out_eop, empty: out_empty};
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               n_checks++;
               if (!out_valid || cur !== prev) begin
                  n_fail++;
                  $display("FAIL hold: got v=%0b d=%0h expected v=1 d=%0h", out_valid,
                           cur.data[31:0], prev.data[31:0]);
               end
            end
            if (out_valid && out_ready) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL beat: got unexpected d=%0h, expected no beat", cur.data[31:0]);
               end else begin
                  e = exp_q.pop_front();
                  if (cur !== e) begin
                     n_fail++;
                     $display("FAIL beat: got d=%0h s=%0b e=%0b m=%0d expected d=%0h s=%0b e=%0b m=%0d",
                              cur.data[31:0], cur.sop, cur.eop, cur.empty,
                              e.data[31:0], e.sop, e.eop, e.empty);
                  end
               end
            end
            prev_stall = out_valid && !out_ready;
            prev       = cur;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      mac_valid = 1'b0;
      mac_sop   = 1'b0;
      mac_eop   = 1'b0;
      mac_data  = '0;
      mac_empty = '0;
`ifdef ETH_RX_FCS_DROP_EN
      mac_error = 1'b0;
`endif
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk_counts("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single sop+eop beat: out_valid two edges after the write edge
      send(1, 0, 1'b1, 1'b1, 6'd5, 1'b0, 1'b1);
      idle();
      exp_pkt++;
      @(negedge clk);
      chk("lat_e0", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      chk("lat_e1", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      chk("lat_e2", {63'd0, out_valid}, 64'd1);
      wait_drain("t1", 20);
      chk_counts("t1");

      // 3-beat packet held under backpressure, then back-to-back drain
      set_ready(1'b0);
      send_pkt(2, 3, 6'd11, 1'b1);
      idle();
      exp_pkt++;
      repeat (10) @(posedge clk);
      #1;
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("b2b", {63'd0, out_valid}, 64'd1);
      end
      wait_drain("t2", 20);
      chk_counts("t2");

      // sop, beat, sop, beat, eop: partial dropped, restarted packet kept
      send(3, 0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
      send(3, 1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      send(4, 0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
      send(4, 1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
      send(4, 2, 1'b0, 1'b1, 6'd7, 1'b0, 1'b1);
      idle();
      exp_drop++;
      exp_pkt++;
      wait_drain("t3", 20);
      chk_counts("t3");

      // Oversized 25-beat packet dropped, following 2-beat packet kept; stray eop dropped
      send_pkt(5, 25, 6'd3, 1'b0);
      send_pkt(6, 2, 6'd9, 1'b1);
      send(7, 0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0);
      idle();
      exp_drop += 2;
      exp_pkt++;
      wait_drain("t4", 40);
      chk_counts("t4");

      // Fill: 20 x 4-beat packets with no drain; 16 fit, 4 dropped
      set_ready(1'b0);
      for (int p = 0; p < 20; p++) send_pkt(10 + p, 4, 6'd2, p < 16);
      idle();
      exp_pkt  += 16;
      exp_drop += 4;
      repeat (5) @(posedge clk);
      chk_counts("t5_full");
      set_ready(1'b1);
      wait_drain("t5", 300);

`ifdef ETH_RX_FCS_DROP_EN
      // Errored eop drops the packet
      send(8, 0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
      send(8, 1, 1'b0, 1'b1, 6'd1, 1'b1, 1'b0);
      idle();
      exp_drop++;
      wait_drain("fcs", 10);
      chk_counts("fcs");
`endif

      // Reset mid-packet with a committed beat stalled at the output
      set_ready(1'b0);
      send_pkt(30, 1, 6'd0, 1'b1);
      send(31, 0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
      send(31, 1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst_n     = 1'b0;
      mac_valid = 1'b0;
      mac_sop   = 1'b0;
      mac_eop   = 1'b0;
      exp_q.delete();
      exp_pkt  = 0;
      exp_drop = 0;
      @(negedge clk);
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_data", out_data[63:0], 64'd0);
      chk("mid_rst_sop", {63'd0, out_sop}, 64'd0);
      chk_counts("mid_rst");
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      send_pkt(32, 2, 6'd4, 1'b1);
      idle();
      exp_pkt++;
      wait_drain("post_rst", 20);
      chk_counts("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
